// File: rtl/u712_chip_ram_dq_if.sv
// u712_chip_ram_dq_if
// Bus bundle between the U712 chip RAM controller side and the DQ/DQM stage.
//   master : controller/bench side; drives SDRAM command pins, cycle-owner
//            flags, 68040 size/address, raw Agnus CAS strobes, DMA word
//            select and the SDRAM DQ input; observes DQM and read data.
//   slave  : u712_chip_ram_dq; drives DQM, RDATA, RDATA_VALID.
interface u712_chip_ram_dq_if;
  logic        CRCSn;
  logic        RASn;
  logic        CASn;
  logic        WEn;
  logic        CPU_CYCLE;
  logic        DMA_CYCLE;
  logic [1:0]  SIZ;
  logic [1:0]  A;
  logic        CASLn;
  logic        CASUn;
  logic        DMA_WORD;
  logic [31:0] DQ_IN;
  logic [3:0]  DQM;
  logic [31:0] RDATA;
  logic        RDATA_VALID;

  modport master (
    output CRCSn, RASn, CASn, WEn, CPU_CYCLE, DMA_CYCLE, SIZ, A,
           CASLn, CASUn, DMA_WORD, DQ_IN,
    input  DQM, RDATA, RDATA_VALID
  );

  modport slave (
    input  CRCSn, RASn, CASn, WEn, CPU_CYCLE, DMA_CYCLE, SIZ, A,
           CASLn, CASUn, DMA_WORD, DQ_IN,
    output DQM, RDATA, RDATA_VALID
  );
endinterface

// File: rtl/u712_chip_ram_dq.sv
// u712_chip_ram_dq
// Byte-lane mask and read-data capture stage downstream of the U712 chip RAM
// SDRAM controller. Watches the registered SDRAM command pins and cycle-owner
// flags, drives the four DQM lanes for CPU (68040) and Agnus DMA accesses and
// captures 32-bit read data CAS_LATENCY cycles after READ, with a one-cycle
// RDATA_VALID strobe.
// Ports:
//   CLK80  : system clock, all logic on the falling edge (as the controller)
//   RESETn : synchronous active-low reset, sampled on the falling edge
//   bus    : slave side of u712_chip_ram_dq_if (command pins, owner flags,
//            SIZ/A, raw CASLn/CASUn, DMA_WORD, DQ_IN in; DQM, RDATA,
//            RDATA_VALID out)
// Parameter CAS_LATENCY (2 or 3) must match the controller's mode register.
module u712_chip_ram_dq #(
  parameter int unsigned CAS_LATENCY = 2
) (
  input logic            CLK80,
  input logic            RESETn,
  u712_chip_ram_dq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, WDONE, RWAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  dqm_q, dqm_d;
  logic [31:0] rdata_q;
  logic        valid_q;
  logic        capture;
  logic [1:0]  casl_sync, casu_sync;
  logic [3:0]  mask_now;
  logic        is_act, is_read, is_write, is_pre, owned;
  logic        both_hi, en_u, en_l;
  logic [31:0] lane_en;

  always_comb begin
    is_act   = ({bus.CRCSn, bus.RASn, bus.CASn, bus.WEn} == 4'b0011);
    is_read  = ({bus.CRCSn, bus.RASn, bus.CASn, bus.WEn} == 4'b0101);
    is_write = ({bus.CRCSn, bus.RASn, bus.CASn, bus.WEn} == 4'b0100);
    is_pre   = ({bus.CRCSn, bus.RASn, bus.CASn, bus.WEn} == 4'b0010);
    owned    = bus.CPU_CYCLE | bus.DMA_CYCLE;
  end

  // Agnus CAS strobes are asynchronous; only the second flop is used.
  always_ff @(negedge CLK80) begin
    if (!RESETn) begin
      casl_sync <= '1;
      casu_sync <= '1;
    end else begin
      casl_sync <= {casl_sync[0], bus.CASLn};
      casu_sync <= {casu_sync[0], bus.CASUn};
    end
  end

  // Lane mask for the access being opened; DMA ownership takes priority.
  // With both synced strobes high the whole selected word is enabled.
  always_comb begin
    both_hi  = casu_sync[1] & casl_sync[1];
    en_u     = ~casu_sync[1] | both_hi;
    en_l     = ~casl_sync[1] | both_hi;
    mask_now = '0;
    if (bus.DMA_CYCLE) begin
      mask_now = bus.DMA_WORD ? {2'b11, ~en_u, ~en_l} : {~en_u, ~en_l, 2'b11};
    end else begin
      case (bus.SIZ)
        2'b01: begin
          case (bus.A)
            2'b00:   mask_now = 4'b0111;
            2'b01:   mask_now = 4'b1011;
            2'b10:   mask_now = 4'b1101;
            default: mask_now = 4'b1110;
          endcase
        end
        2'b10:   mask_now = bus.A[1] ? 4'b1100 : 4'b0011;
        default: mask_now = '0;
      endcase
    end
  end

  always_ff @(negedge CLK80) begin
    if (!RESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (is_act && owned) state_d = ARMED;
      ARMED: begin
        if (is_write) begin
          state_d = WDONE;
        end else if (is_read) begin
          state_d = RWAIT;
          cnt_d   = 2'(CAS_LATENCY);
        end else if (is_pre || !owned) begin
          state_d = IDLE;
        end
      end
      WDONE: state_d = IDLE;
      RWAIT: begin
        // PRECHARGE is deliberately ignored here: the capture always completes.
        if (cnt_q == 2'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dqm_d   = dqm_q;
    capture = 1'b0;
    case (state_q)
      IDLE:  dqm_d = (state_d == ARMED) ? mask_now : '1;
      ARMED: if (state_d == IDLE) dqm_d = '1;
      WDONE: dqm_d = '1;
      RWAIT: begin
        if (state_d == IDLE) begin
          capture = 1'b1;
          dqm_d   = '1;
        end
      end
      default: dqm_d = '1;
    endcase
  end

  // DQM still holds the access mask on the capture edge, so it selects lanes.
  always_comb begin
    lane_en = {{8{~dqm_q[3]}}, {8{~dqm_q[2]}}, {8{~dqm_q[1]}}, {8{~dqm_q[0]}}};
  end

  always_ff @(negedge CLK80) begin
    if (!RESETn) begin
      dqm_q   <= '1;
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      dqm_q   <= dqm_d;
      valid_q <= capture;
      if (capture) rdata_q <= bus.DQ_IN & lane_en;
    end
  end

  assign bus.DQM         = dqm_q;
  assign bus.RDATA       = rdata_q;
  assign bus.RDATA_VALID = valid_q;

endmodule

// File: tb/tb_u712_chip_ram_dq.sv
// tb_u712_chip_ram_dq
// Directed bench for u712_chip_ram_dq. Two instances (CAS latency 2 and 3)
// see identical stimulus; expected read data is queued with its due cycle
// when READ is driven and compared when that cycle's edge has passed.
module tb_u712_chip_ram_dq;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } exp_t;

  logic        CLK80 = 1'b1;
  logic        rstn;
  logic        crcsn, rasn, casn, wen, cpu, dma, casl, casu, dword;
  logic [1:0]  siz, a;
  logic [31:0] dq;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        q2[$];
  exp_t        q3[$];
  logic [31:0] last2 = '0;
  logic [31:0] last3 = '0;

  u712_chip_ram_dq_if b2 ();
  u712_chip_ram_dq_if b3 ();

  assign b2.CRCSn = crcsn;  assign b3.CRCSn = crcsn;
  assign b2.RASn = rasn;    assign b3.RASn = rasn;
  assign b2.CASn = casn;    assign b3.CASn = casn;
  assign b2.WEn = wen;      assign b3.WEn = wen;
  assign b2.CPU_CYCLE = cpu; assign b3.CPU_CYCLE = cpu;
  assign b2.DMA_CYCLE = dma; assign b3.DMA_CYCLE = dma;
  assign b2.SIZ = siz;      assign b3.SIZ = siz;
  assign b2.A = a;          assign b3.A = a;
  assign b2.CASLn = casl;   assign b3.CASLn = casl;
  assign b2.CASUn = casu;   assign b3.CASUn = casu;
  assign b2.DMA_WORD = dword; assign b3.DMA_WORD = dword;
  assign b2.DQ_IN = dq;     assign b3.DQ_IN = dq;

  u712_chip_ram_dq #(.CAS_LATENCY(2)) dut2 (.CLK80(CLK80), .RESETn(rstn), .bus(b2));
  u712_chip_ram_dq #(.CAS_LATENCY(3)) dut3 (.CLK80(CLK80), .RESETn(rstn), .bus(b3));

  always #5 CLK80 = ~CLK80;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic cmd(input logic [3:0] c);
    {crcsn, rasn, casn, wen} = c;
  endtask

  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101,
                         C_WR = 4'b0100, C_PRE = 4'b0010;

  // Drive READ now; it is sampled on the next edge (cyc+1).
  task automatic read_cmd(input logic [31:0] dq_v, input logic [31:0] exp_v);
    exp_t e;
    cmd(C_RD);
    dq = dq_v;
    e.data = exp_v;
    e.due = cyc + 1 + 2; q2.push_back(e);
    e.due = cyc + 1 + 3; q3.push_back(e);
  endtask

  task automatic step(input logic [3:0] e2, input logic [3:0] e3, input string tag);
    exp_t e;
    logic ev;
    @(negedge CLK80);
    #1;
    cyc++;
    chk({tag, " dqm2"}, {28'd0, b2.DQM}, {28'd0, e2});
    chk({tag, " dqm3"}, {28'd0, b3.DQM}, {28'd0, e3});
    ev = (q2.size() > 0) && (q2[0].due == cyc);
    chk({tag, " valid2"}, {31'd0, b2.RDATA_VALID}, {31'd0, ev});
    if (ev) begin e = q2.pop_front(); last2 = e.data; end
    chk({tag, " rdata2"}, b2.RDATA, last2);
    ev = (q3.size() > 0) && (q3[0].due == cyc);
    chk({tag, " valid3"}, {31'd0, b3.RDATA_VALID}, {31'd0, ev});
    if (ev) begin e = q3.pop_front(); last3 = e.data; end
    chk({tag, " rdata3"}, b3.RDATA, last3);
  endtask

  task automatic idle(input int unsigned n);
    cmd(C_NOP);
    for (int unsigned i = 0; i < n; i++) step(4'hF, 4'hF, "idle");
  endtask

  initial begin
    rstn = 1'b0; cmd(C_NOP); cpu = 0; dma = 0; siz = 2'b00; a = 2'b00;
    casl = 1; casu = 1; dword = 0; dq = '0;
    step(4'hF, 4'hF, "reset"); step(4'hF, 4'hF, "reset");
    rstn = 1'b1;
    idle(2);

    // ACT with no owner is ignored
    cmd(C_ACT); step(4'hF, 4'hF, "act_noown");
    idle(2);

    // CPU long read
    cpu = 1; siz = 2'b00; a = 2'b00;
    cmd(C_ACT); step(4'h0, 4'h0, "t1_act");
    cmd(C_NOP); step(4'h0, 4'h0, "t1_gap");
    read_cmd(32'hDEADBEEF, 32'hDEADBEEF); step(4'h0, 4'h0, "t1_read");
    cmd(C_NOP); step(4'h0, 4'h0, "t1_r1");
    step(4'hF, 4'h0, "t1_r2");
    step(4'hF, 4'hF, "t1_r3");
    cpu = 0; idle(4);

    // CPU byte write, A=10
    cpu = 1; siz = 2'b01; a = 2'b10;
    cmd(C_ACT); step(4'hD, 4'hD, "t2_act");
    cmd(C_NOP); step(4'hD, 4'hD, "t2_gap");
    cmd(C_WR);  step(4'hD, 4'hD, "t2_wr");
    cmd(C_NOP); step(4'hF, 4'hF, "t2_done");
    cpu = 0; idle(4);

    // CPU word read, A=01 (A0 ignored) -> upper word
    cpu = 1; siz = 2'b10; a = 2'b01;
    cmd(C_ACT); step(4'h3, 4'h3, "tw_act");
    cmd(C_NOP); step(4'h3, 4'h3, "tw_gap");
    read_cmd(32'hCAFEF00D, 32'hCAFE0000); step(4'h3, 4'h3, "tw_read");
    cmd(C_NOP); step(4'h3, 4'h3, "tw_r1");
    step(4'hF, 4'h3, "tw_r2");
    step(4'hF, 4'hF, "tw_r3");
    cpu = 0; idle(4);

    // DMA read lower word, CPU flag also high (DMA wins), PRECHARGE mid-read
    casl = 0; casu = 0; dword = 1; siz = 2'b01; a = 2'b00;
    cmd(C_NOP); step(4'hF, 4'hF, "t3_sync"); step(4'hF, 4'hF, "t3_sync");
    dma = 1; cpu = 1;
    cmd(C_ACT); step(4'hC, 4'hC, "t3_act");
    cmd(C_NOP); step(4'hC, 4'hC, "t3_gap");
    read_cmd(32'h12345678, 32'h00005678); step(4'hC, 4'hC, "t3_read");
    cmd(C_PRE); step(4'hC, 4'hC, "t3_pre");
    cmd(C_NOP); step(4'hF, 4'hC, "t3_r2");
    step(4'hF, 4'hF, "t3_r3");
    dma = 0; cpu = 0; casl = 1; casu = 1; idle(4);

    // DMA write, upper word, upper byte only
    dword = 0; casu = 0; casl = 1;
    step(4'hF, 4'hF, "t4_sync"); step(4'hF, 4'hF, "t4_sync");
    dma = 1;
    cmd(C_ACT); step(4'h7, 4'h7, "t4_act");
    cmd(C_NOP); step(4'h7, 4'h7, "t4_gap");
    cmd(C_WR);  step(4'h7, 4'h7, "t4_wr");
    cmd(C_NOP); step(4'hF, 4'hF, "t4_done");
    dma = 0; casu = 1; idle(3);

    // DMA with both strobes high enables the whole selected word; PRECHARGE aborts
    dma = 1;
    cmd(C_ACT); step(4'h3, 4'h3, "tb_act");
    cmd(C_PRE); step(4'hF, 4'hF, "tb_pre");
    dma = 0; idle(3);

    // CPU access aborted by owner flags dropping; byte A=11
    cpu = 1; siz = 2'b01; a = 2'b11;
    cmd(C_ACT); step(4'hE, 4'hE, "t5a_act");
    cpu = 0; cmd(C_NOP); step(4'hF, 4'hF, "t5a_drop");
    idle(3);

    // Reset the cycle after READ drops the capture
    cpu = 1; siz = 2'b00;
    cmd(C_ACT); step(4'h0, 4'h0, "t5b_act");
    cmd(C_NOP); step(4'h0, 4'h0, "t5b_gap");
    read_cmd(32'h0BADF00D, 32'h0BADF00D); step(4'h0, 4'h0, "t5b_read");
    rstn = 1'b0; cmd(C_NOP);
    q2.delete(); q3.delete(); last2 = '0; last3 = '0;
    step(4'hF, 4'hF, "t5b_rst"); step(4'hF, 4'hF, "t5b_rst");
    rstn = 1'b1; cpu = 0;
    idle(5);

    chk("sb2_empty", q2.size(), 0);
    chk("sb3_empty", q3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
